// File: rtl/mem_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_init_pkg
//  Description : Shared types and helpers for the memory-initialisation
//                sequencer (data modes, FSM states, index sizing).
//  Revision    : 1.0  initial release
// ============================================================================
package mem_init_pkg;

    // Data pattern selected at start of a run
    typedef enum logic [1:0] {
        MODE_IDENTITY = 2'd0,
        MODE_FILL     = 2'd1,
        MODE_REVERSE  = 2'd2,
        MODE_AFFINE   = 2'd3
    } init_mode_t;

    // Sequencer control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Index width able to represent the value DEPTH itself, so that the
    // "last index + 1" computation never wraps.
    function automatic int idx_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : mem_init_pkg
`default_nettype wire

// File: rtl/init_data_gen.sv
`default_nettype none
// ============================================================================
//  Module      : init_data_gen
//  Description : Write-data generator for mem_init_seq. Produces the data
//                word for the next presented write (either the first word of
//                a run or the word following a taken write) and keeps the
//                running accumulator used by the affine mode.
//  Revision    : 1.0  initial release
// ============================================================================
module init_data_gen
    import mem_init_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,   // run accepted this edge
    input  logic              take_i,    // presented write taken this edge
    input  logic [1:0]        mode_i,    // effective mode for the next word
    input  logic [DATA_W-1:0] seed_i,    // effective seed for the next word
    input  logic [DATA_W-1:0] step_i,    // latched affine increment
    input  logic [IDX_W-1:0]  idx_i,     // index of the next word
    output logic [DATA_W-1:0] data_o     // data of the next word
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [IDX_W-1:0]  w_rev;

    // Accumulator tracks seed + i*step for the word currently presented;
    // reload on accept, advance by step on every taken write.
    always_comb begin
        acc_d = acc_q;
        if (start_i) begin
            acc_d = seed_i;
        end else if (take_i) begin
            acc_d = acc_q + step_i;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Index never exceeds DEPTH-1 when used, so this subtraction cannot wrap
    assign w_rev = c_LAST - idx_i;

    // Select the next data word by mode; all results truncate to DATA_W
    always_comb begin
        data_o = '0;
        case (init_mode_t'(mode_i))
            MODE_IDENTITY: data_o = DATA_W'(idx_i);
            MODE_FILL:     data_o = seed_i;
            MODE_REVERSE:  data_o = DATA_W'(w_rev);
            MODE_AFFINE:   data_o = acc_d;
            default:       data_o = '0;
        endcase
    end

endmodule : init_data_gen
`default_nettype wire

// File: rtl/mem_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_init_seq
//  Description : Parametrised memory-initialisation sequencer. After an
//                accepted start it presents DEPTH consecutive writes
//                (address 0..DEPTH-1) with data chosen by mode, honours
//                write back-pressure and pulses done after the last write.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_init_seq
    import mem_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic              rdy_o,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [DATA_W-1:0] step_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wrdata_o,
    output logic              wren_o,
    output logic              done_o
);

    localparam int               IDX_W  = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t            state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [1:0]        mode_q,   mode_d;
    logic [DATA_W-1:0] seed_q,   seed_d;
    logic [DATA_W-1:0] step_q,   step_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              wren_q,   wren_d;
    logic              done_q,   done_d;
    logic              rdy_q,    rdy_d;

    // ------------------------------------------------------------------
    // Handshake strobes
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_take;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [1:0]        w_gen_mode;
    logic [DATA_W-1:0] w_gen_seed;
    logic [DATA_W-1:0] w_gen_data;

    // rdy is high exactly in IDLE and DONE, so it doubles as the accept gate
    assign w_accept  = en_i && rdy_q;
    assign w_take    = (state_q == S_WRITE) && wren_q && !stall_i;
    assign w_last    = (idx_q == c_LAST);

    // On accept the generator sees the raw inputs and index 0; otherwise the
    // latched run configuration and the index following the current one.
    assign w_idx_nxt  = w_accept ? '0     : (idx_q + 1'b1);
    assign w_gen_mode = w_accept ? mode_i : mode_q;
    assign w_gen_seed = w_accept ? seed_i : seed_q;

    init_data_gen #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_data_gen (
        .clk     (clk),
        .rst     (rst),
        .start_i (w_accept),
        .take_i  (w_take),
        .mode_i  (w_gen_mode),
        .seed_i  (w_gen_seed),
        .step_i  (step_q),
        .idx_i   (w_idx_nxt),
        .data_o  (w_gen_data)
    );

    // Next-state and registered-output logic for the IDLE/WRITE/DONE FSM
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        seed_d   = seed_q;
        step_d   = step_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = wren_q;
        done_d   = 1'b0;
        rdy_d    = rdy_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                wren_d  = 1'b0;
                if (w_accept) begin
                    state_d  = S_WRITE;
                    mode_d   = mode_i;
                    seed_d   = seed_i;
                    step_d   = step_i;
                    idx_d    = '0;
                    addr_d   = '0;
                    wrdata_d = w_gen_data;
                    wren_d   = 1'b1;
                    rdy_d    = 1'b0;
                end
            end

            S_WRITE: begin
                // A stalled cycle leaves every output register untouched
                if (w_take) begin
                    if (w_last) begin
                        state_d = S_DONE;
                        wren_d  = 1'b0;
                        done_d  = 1'b1;
                        rdy_d   = 1'b1;
                    end else begin
                        idx_d    = w_idx_nxt;
                        addr_d   = ADDR_W'(w_idx_nxt);
                        wrdata_d = w_gen_data;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                wren_d  = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mode_q   <= '0;
            seed_q   <= '0;
            step_q   <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            seed_q   <= seed_d;
            step_q   <= step_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
        end
    end

    assign rdy_o    = rdy_q;
    assign addr_o   = addr_q;
    assign wrdata_o = wrdata_q;
    assign wren_o   = wren_q;
    assign done_o   = done_q;

endmodule : mem_init_seq
`default_nettype wire

// File: tb/tb_mem_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_init_seq
//  Description : Scoreboard bench for mem_init_seq. Four instances
//                (DEPTH 256, 16, 200, 1) share clock, reset and data
//                inputs; each has its own start request. Expected writes and
//                done pulses are queued at stimulus time and consumed by an
//                independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_init_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_v;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [7:0]  step;
    logic        stall;

    logic [3:0]  rdy_w;
    logic [3:0]  wren_w;
    logic [3:0]  done_w;
    logic [7:0]  addr_w [4];
    logic [7:0]  data_w [4];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         inst;
        bit         is_done;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_a (
        .clk(clk), .rst(rst), .en_i(en_v[0]), .rdy_o(rdy_w[0]),
        .mode_i(mode), .seed_i(seed), .step_i(step), .stall_i(stall),
        .addr_o(addr_w[0]), .wrdata_o(data_w[0]), .wren_o(wren_w[0]), .done_o(done_w[0]));

    mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) u_f (
        .clk(clk), .rst(rst), .en_i(en_v[1]), .rdy_o(rdy_w[1]),
        .mode_i(mode), .seed_i(seed), .step_i(step), .stall_i(stall),
        .addr_o(addr_w[1]), .wrdata_o(data_w[1]), .wren_o(wren_w[1]), .done_o(done_w[1]));

    mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) u_r (
        .clk(clk), .rst(rst), .en_i(en_v[2]), .rdy_o(rdy_w[2]),
        .mode_i(mode), .seed_i(seed), .step_i(step), .stall_i(stall),
        .addr_o(addr_w[2]), .wrdata_o(data_w[2]), .wren_o(wren_w[2]), .done_o(done_w[2]));

    mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(1)) u_s (
        .clk(clk), .rst(rst), .en_i(en_v[3]), .rdy_o(rdy_w[3]),
        .mode_i(mode), .seed_i(seed), .step_i(step), .stall_i(stall),
        .addr_o(addr_w[3]), .wrdata_o(data_w[3]), .wren_o(wren_w[3]), .done_o(done_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_write(input int k, input int a, input int d);
        exp_t e;
        e.inst    = k;
        e.is_done = 1'b0;
        e.addr    = a[7:0];
        e.data    = d[7:0];
        sb.push_back(e);
    endtask

    task automatic push_done(input int k);
        exp_t e;
        e.inst    = k;
        e.is_done = 1'b1;
        e.addr    = 8'h00;
        e.data    = 8'h00;
        sb.push_back(e);
    endtask

    // Issue a one-cycle start to instance k, then scramble the shared inputs
    task automatic start(input int k, input logic [1:0] m, input logic [7:0] s, input logic [7:0] st);
        mode    = m;
        seed    = s;
        step    = st;
        en_v[k] = 1'b1;
        @(posedge clk); #1;
        en_v[k] = 1'b0;
        mode    = ~m;
        seed    = ~s;
        step    = st + 8'd1;
    endtask

    // Count cycles (current cycle = 1) until done is seen on instance k
    task automatic run_to_done(input int k, input int budget, output int cyc, output int low);
        int n;
        n   = 1;
        cyc = 0;
        low = 0;
        while (n <= budget) begin
            if (done_w[k] === 1'b1) begin
                cyc = n;
                break;
            end
            if (rdy_w[k] === 1'b0) low++;
            @(posedge clk); #1;
            n++;
        end
        if (cyc == 0) begin
            checks++;
            fails++;
            $display("FAIL done_timeout inst %0d: got no done within %0d cycles, required a done pulse", k, budget);
        end
    endtask

    // Monitor: every taken write and every done pulse must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (wren_w[k] === 1'b1 && stall === 1'b0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_write inst %0d: got addr %0d data %0d, required no write",
                                 k, addr_w[k], data_w[k]);
                    end else begin
                        e = sb.pop_front();
                        if (e.inst != k || e.is_done || addr_w[k] !== e.addr || data_w[k] !== e.data) begin
                            fails++;
                            $display("FAIL write inst %0d: got addr %0d data %0d, required inst %0d done %0d addr %0d data %0d",
                                     k, addr_w[k], data_w[k], e.inst, e.is_done, e.addr, e.data);
                        end
                    end
                end
                if (done_w[k] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done inst %0d: got done, required no done", k);
                    end else begin
                        e = sb.pop_front();
                        if (e.inst != k || !e.is_done) begin
                            fails++;
                            $display("FAIL done inst %0d: got done, required inst %0d done %0d addr %0d",
                                     k, e.inst, e.is_done, e.addr);
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, low, n;

        rst   = 1'b1;
        en_v  = 4'b0000;
        mode  = 2'd0;
        seed  = 8'h00;
        step  = 8'h00;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("reset_rdy",    rdy_w[0],  1);
        check("reset_wren",   wren_w[0], 0);
        check("reset_done",   done_w[0], 0);
        check("reset_addr",   addr_w[0], 0);
        check("reset_wrdata", data_w[0], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity, DEPTH 256, no stall
        for (int i = 0; i < 256; i++) push_write(0, i, i);
        push_done(0);
        start(0, 2'd0, 8'h00, 8'h00);
        run_to_done(0, 400, cyc, low);
        check("ident_done_cycle", cyc, 257);
        check("ident_rdy_low",    low, 256);
        @(posedge clk); #1;
        check("ident_done_pulse", done_w[0], 0);
        check("ident_wren_after", wren_w[0], 0);

        // Fill A5, DEPTH 16
        for (int i = 0; i < 16; i++) push_write(1, i, 8'hA5);
        push_done(1);
        start(1, 2'd1, 8'hA5, 8'h00);
        run_to_done(1, 50, cyc, low);
        check("fill_done_cycle", cyc, 17);
        @(posedge clk); #1;
        check("fill_wren_after", wren_w[1], 0);
        check("fill_done_pulse", done_w[1], 0);

        // Reverse, DEPTH 200
        for (int i = 0; i < 200; i++) push_write(2, i, 199 - i);
        push_done(2);
        start(2, 2'd2, 8'h00, 8'h00);
        run_to_done(2, 300, cyc, low);
        check("rev_done_cycle", cyc, 201);
        @(posedge clk); #1;
        check("rev_rdy_after", rdy_w[2], 1);

        // Affine seed 3 step 7: addr 36 -> 255, addr 37 -> 6
        for (int i = 0; i < 256; i++) push_write(0, i, (3 + 7 * i) % 256);
        push_done(0);
        start(0, 2'd3, 8'd3, 8'd7);
        run_to_done(0, 400, cyc, low);
        check("affine_done_cycle", cyc, 257);
        @(posedge clk); #1;

        // Three stalled cycles while addr 5 is presented
        for (int i = 0; i < 256; i++) push_write(0, i, i);
        push_done(0);
        start(0, 2'd0, 8'h00, 8'h00);
        n = 1;
        while (!(wren_w[0] === 1'b1 && addr_w[0] === 8'd5) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_reach_cycle", n, 6);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            check("stall_hold", {addr_w[0], data_w[0], wren_w[0]}, {8'd5, 8'd5, 1'b1});
        end
        stall = 1'b0;
        run_to_done(0, 400, cyc, low);
        check("stall_done_cycle", n + 3 + cyc - 1, 260);
        @(posedge clk); #1;

        // Mid-run en ignored, then back-to-back start in the DONE cycle
        for (int i = 0; i < 16; i++) push_write(1, i, 8'h3C);
        push_done(1);
        start(1, 2'd1, 8'h3C, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        mode    = 2'd0;
        seed    = 8'hFF;
        en_v[1] = 1'b1;
        @(posedge clk); #1;
        en_v[1] = 1'b0;
        check("midrun_rdy", rdy_w[1], 0);
        run_to_done(1, 50, cyc, low);
        check("midrun_done_cycle", cyc, 13);
        for (int i = 0; i < 16; i++) push_write(1, i, i);
        push_done(1);
        mode    = 2'd0;
        en_v[1] = 1'b1;
        @(posedge clk); #1;
        en_v[1] = 1'b0;
        check("b2b_first_write", {wren_w[1], rdy_w[1], addr_w[1], data_w[1]}, {1'b1, 1'b0, 8'd0, 8'd0});
        run_to_done(1, 50, cyc, low);
        check("b2b_done_cycle", cyc, 17);
        @(posedge clk); #1;

        // DEPTH 1: single write then done
        push_write(3, 0, 8'h5A);
        push_done(3);
        start(3, 2'd1, 8'h5A, 8'h00);
        run_to_done(3, 10, cyc, low);
        check("depth1_done_cycle", cyc, 2);
        @(posedge clk); #1;

        // Reset at addr 100 (with en on the same edge): abandon, no done
        for (int i = 0; i < 100; i++) push_write(0, i, i);
        start(0, 2'd0, 8'h00, 8'h00);
        n = 1;
        while (!(wren_w[0] === 1'b1 && addr_w[0] === 8'd100) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_reach_cycle", n, 101);
        stall   = 1'b1;
        rst     = 1'b1;
        en_v[0] = 1'b1;
        @(posedge clk); #1;
        check("rst_wren", wren_w[0], 0);
        check("rst_rdy",  rdy_w[0],  1);
        check("rst_done", done_w[0], 0);
        check("rst_addr", addr_w[0], 0);
        rst     = 1'b0;
        stall   = 1'b0;
        en_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_mem_init_seq
`default_nettype wire
